// File: rtl/hdmi_video_timing.sv
// rtl/hdmi_video_timing.sv - 1080p60 raster timing generator gated by PLL lock
module hdmi_video_timing #(
    parameter int   H_ACTIVE  = 1920,
    parameter int   H_FRONT   = 88,
    parameter int   H_SYNC    = 44,
    parameter int   H_BACK    = 148,
    parameter int   V_ACTIVE  = 1080,
    parameter int   V_FRONT   = 4,
    parameter int   V_SYNC    = 5,
    parameter int   V_BACK    = 36,
    parameter logic HS_POL    = 1'b1,
    parameter logic VS_POL    = 1'b1,
    parameter int   LOCK_WAIT = 1024
) (
    input  logic        refclk,
    input  logic        rst,
    input  logic        locked,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        frame_start,
    output logic        running
);

    localparam logic [1:0] WAIT_LOCK = 2'd0;
    localparam logic [1:0] SETTLE    = 2'd1;
    localparam logic [1:0] RUN       = 2'd2;

    localparam logic [11:0] H_LAST   = 12'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [11:0] V_LAST   = 12'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
    localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FRONT);
    localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FRONT);
    localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FRONT + V_SYNC);

    // Settle counter only ever reaches LOCK_WAIT-1
    localparam int          SW          = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(LOCK_WAIT - 1);

    logic          lock_meta_q, lock_meta_d;
    logic          locked_s_q, locked_s_d;
    logic [1:0]    state_q, state_d;
    logic [SW-1:0] settle_cnt_q, settle_cnt_d;
    logic [11:0]   h_cnt_q, h_cnt_d;
    logic [11:0]   v_cnt_q, v_cnt_d;
    logic          running_q, running_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          de_q, de_d;
    logic [11:0]   x_q, x_d;
    logic [11:0]   y_q, y_d;
    logic          frame_start_q, frame_start_d;
    logic          in_run;

    // Lock synchronizer, lock qualification FSM and raster counters
    always_comb begin
        lock_meta_d  = locked;
        locked_s_d   = lock_meta_q;
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        h_cnt_d      = h_cnt_q;
        v_cnt_d      = v_cnt_q;
        if (!locked_s_q) begin
            // Any lock loss abandons the frame; restart is always from (0,0)
            state_d      = WAIT_LOCK;
            settle_cnt_d = '0;
            h_cnt_d      = '0;
            v_cnt_d      = '0;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    state_d      = SETTLE;
                    settle_cnt_d = '0;
                    h_cnt_d      = '0;
                    v_cnt_d      = '0;
                end
                SETTLE: begin
                    if (settle_cnt_q == SETTLE_LAST) begin
                        state_d = RUN;
                        h_cnt_d = '0;
                        v_cnt_d = '0;
                    end else begin
                        settle_cnt_d = settle_cnt_q + SW'(1);
                    end
                end
                RUN: begin
                    if (h_cnt_q == H_LAST) begin
                        h_cnt_d = '0;
                        v_cnt_d = (v_cnt_q == V_LAST) ? 12'd0 : v_cnt_q + 12'd1;
                    end else begin
                        h_cnt_d = h_cnt_q + 12'd1;
                    end
                end
                default: begin
                    state_d      = WAIT_LOCK;
                    settle_cnt_d = '0;
                    h_cnt_d      = '0;
                    v_cnt_d      = '0;
                end
            endcase
        end
        running_d = (state_d == RUN);
    end

    // Output decode from the current counters; idle levels outside RUN
    always_comb begin
        in_run        = (state_q == RUN);
        de_d          = in_run && (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        hsync_d       = (in_run && (h_cnt_q >= HS_START) && (h_cnt_q < HS_END)) ? HS_POL : ~HS_POL;
        vsync_d       = (in_run && (v_cnt_q >= VS_START) && (v_cnt_q < VS_END)) ? VS_POL : ~VS_POL;
        x_d           = de_d ? h_cnt_q : 12'd0;
        y_d           = de_d ? v_cnt_q : 12'd0;
        frame_start_d = in_run && (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            lock_meta_q   <= 1'b0;
            locked_s_q    <= 1'b0;
            state_q       <= WAIT_LOCK;
            settle_cnt_q  <= '0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            running_q     <= 1'b0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            de_q          <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            frame_start_q <= 1'b0;
        end else begin
            lock_meta_q   <= lock_meta_d;
            locked_s_q    <= locked_s_d;
            state_q       <= state_d;
            settle_cnt_q  <= settle_cnt_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            running_q     <= running_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            x_q           <= x_d;
            y_q           <= y_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign x           = x_q;
    assign y           = y_q;
    assign frame_start = frame_start_q;
    assign running     = running_q;

endmodule
